// File: rtl/punc_fetch_branch_unit_pkg.sv
// Shared constants for the PUnC fetch/branch slice: opcodes, control-state
// encodings and architectural reset values.
package punc_fetch_branch_unit_pkg;

  localparam logic [3:0] OC_BR  = 4'b0000;
  localparam logic [3:0] OC_ADD = 4'b0001;
  localparam logic [3:0] OC_LD  = 4'b0010;
  localparam logic [3:0] OC_ST  = 4'b0011;
  localparam logic [3:0] OC_JSR = 4'b0100;
  localparam logic [3:0] OC_AND = 4'b0101;
  localparam logic [3:0] OC_LDR = 4'b0110;
  localparam logic [3:0] OC_STR = 4'b0111;
  localparam logic [3:0] OC_RTI = 4'b1000;
  localparam logic [3:0] OC_NOT = 4'b1001;
  localparam logic [3:0] OC_LDI = 4'b1010;
  localparam logic [3:0] OC_STI = 4'b1011;
  localparam logic [3:0] OC_JMP = 4'b1100;
  localparam logic [3:0] OC_RES = 4'b1101;
  localparam logic [3:0] OC_LEA = 4'b1110;
  localparam logic [3:0] OC_HLT = 4'b1111;

  typedef enum logic [2:0] {
    STATE_FETCH   = 3'b001,
    STATE_DECODE  = 3'b010,
    STATE_EXECUTE = 3'b100
  } state_t;

  localparam logic [2:0]  NZP_RESET      = 3'b010;
  localparam logic [15:0] RST_PC_DEFAULT = 16'h0000;

  // Exactly one flag is set for any input value.
  function automatic logic [2:0] calc_nzp(input logic [15:0] value);
    calc_nzp = {value[15], value == 16'h0000, !value[15] && (value != 16'h0000)};
  endfunction

endpackage

// File: rtl/punc_fetch_branch_unit_sext.sv
// Sign extension of an IN_W-bit instruction field to the datapath width.
module punc_sext #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  field,
  output logic [OUT_W-1:0] ext
);

  assign ext = {{(OUT_W - IN_W){field[IN_W-1]}}, field};

endmodule

// File: rtl/punc_fetch_branch_unit.sv
// PC, instruction register and condition codes of the PUnC LC3 datapath,
// sequenced entirely by the one-hot state supplied by the control FSM.
module punc_fetch_branch_unit
  import punc_fetch_branch_unit_pkg::*;
#(
  parameter logic [15:0] RST_PC = RST_PC_DEFAULT,
  parameter int          W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   state,
  input  logic         ir_w_en,
  input  logic         pc_w_en,
  input  logic         status_w_en,
  input  logic         oc_ldi_first,
  input  logic [W-1:0] mem_rdata,
  input  logic [W-1:0] base_rdata,
  input  logic [W-1:0] wb_data,
  output logic [W-1:0] mem_raddr,
  output logic [W-1:0] pc,
  output logic [W-1:0] ir,
  output logic [3:0]   DPATH_op_code,
  output logic [2:0]   dr,
  output logic [2:0]   sr1,
  output logic [2:0]   sr2,
  output logic [W-1:0] imm5_sext,
  output logic [W-1:0] off6_sext,
  output logic [W-1:0] pc_off9,
  output logic [2:0]   nzp,
  output logic         br_taken
);

  logic [W-1:0] pc_q;
  logic [W-1:0] ir_q;
  logic [2:0]   nzp_q;
  logic [W-1:0] pc_next;
  logic [W-1:0] off9_sext;
  logic [W-1:0] off11_sext;
  logic [W-1:0] pc_off11;
  logic [3:0]   op;
  logic         nzp_blocked;

  assign op = ir_q[15:12];

  punc_sext #(.IN_W(5),  .OUT_W(W)) u_sext5  (.field(ir_q[4:0]),  .ext(imm5_sext));
  punc_sext #(.IN_W(6),  .OUT_W(W)) u_sext6  (.field(ir_q[5:0]),  .ext(off6_sext));
  punc_sext #(.IN_W(9),  .OUT_W(W)) u_sext9  (.field(ir_q[8:0]),  .ext(off9_sext));
  punc_sext #(.IN_W(11), .OUT_W(W)) u_sext11 (.field(ir_q[10:0]), .ext(off11_sext));

  assign pc_off9  = pc_q + off9_sext;
  assign pc_off11 = pc_q + off11_sext;
  assign br_taken = (op == OC_BR) && ((ir_q[11:9] & nzp_q) != 3'b000);

  // The meaning of pc_w_en depends on which control state we are in.
  always_comb begin
    pc_next = pc_q;
    if (state == STATE_DECODE) begin
      if (pc_w_en) pc_next = pc_q + 1'b1;
    end else if (state == STATE_EXECUTE && pc_w_en) begin
      case (op)
        OC_BR:   if (br_taken) pc_next = pc_off9;
        OC_JMP:  pc_next = base_rdata;
        OC_JSR:  pc_next = ir_q[11] ? pc_off11 : base_rdata;
        default: pc_next = pc_q;
      endcase
    end
  end

  // First LDI cycle returns the pointer, not the loaded value.
  always_comb begin
    nzp_blocked = 1'b0;
    case (op)
      OC_BR, OC_ST, OC_STI, OC_STR, OC_JMP, OC_HLT: nzp_blocked = 1'b1;
      OC_LDI:  nzp_blocked = oc_ldi_first;
      default: nzp_blocked = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RST_PC;
      ir_q  <= '0;
      nzp_q <= NZP_RESET;
    end else begin
      pc_q <= pc_next;
      if (ir_w_en && state == STATE_FETCH) ir_q <= mem_rdata;
      if (status_w_en && state == STATE_EXECUTE && !nzp_blocked) nzp_q <= calc_nzp(wb_data);
    end
  end

  assign pc            = pc_q;
  assign mem_raddr     = pc_q;
  assign ir            = ir_q;
  assign nzp           = nzp_q;
  assign DPATH_op_code = ir_q[15:12];
  assign dr            = ir_q[11:9];
  assign sr1           = ir_q[8:6];
  assign sr2           = ir_q[2:0];

endmodule
